// File: rtl/cpsr_sel_reg.sv
// Registered CPSR with per-byte masked source select and a LIFO SPSR save/restore stack.
// Optional CPSR_USER_LOCK_EN: in user mode, masked writes cannot touch the control byte.
module cpsr_sel_reg #(
  parameter int          WIDTH      = 32,
  parameter int          NUM_SRC    = 5,
  parameter int          SEL_W      = 3,
  parameter int          SPSR_DEPTH = 4,
  parameter logic [31:0] RESET_VAL  = 32'h0000_00D3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC*WIDTH-1:0]         src_data,
  input  logic [SEL_W-1:0]                 src_sel,
  input  logic                             wr_en,
  input  logic [WIDTH/8-1:0]               field_mask,
  input  logic                             save_en,
  input  logic                             restore_en,
  output logic [WIDTH-1:0]                 cpsr_out,
  output logic [WIDTH-1:0]                 spsr_top,
  output logic [$clog2(SPSR_DEPTH+1)-1:0]  spsr_count,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             sel_err,
  output logic                             ovf_err,
  output logic                             unf_err
);

  localparam int CW = $clog2(SPSR_DEPTH + 1);
  localparam int NB = WIDTH / 8;
  localparam logic [WIDTH-1:0] RST_CPSR = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cpsr_q, cpsr_d;
  logic [WIDTH-1:0] stack_q [SPSR_DEPTH];
  logic [WIDTH-1:0] stack_d [SPSR_DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             sel_err_q, sel_err_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] src_word;
  logic             sel_valid;
  logic [NB-1:0]    eff_mask;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] top_word;
  logic             is_full;
  logic             is_empty;

  // Source mux is built as a compare loop so out-of-range selects never index past src_data.
  always_comb begin
    src_word  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel == SEL_W'(k)) begin
        src_word  = src_data[k*WIDTH +: WIDTH];
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    eff_mask = field_mask;
`ifdef CPSR_USER_LOCK_EN
    if (cpsr_q[4:0] == 5'b10000) begin
      eff_mask[0] = 1'b0;
    end
`endif
    bit_mask = '0;
    for (int i = 0; i < NB; i++) begin
      bit_mask[8*i +: 8] = {8{eff_mask[i]}};
    end
  end

  always_comb begin
    top_word = '0;
    for (int i = 0; i < SPSR_DEPTH; i++) begin
      if (count_q == CW'(i + 1)) begin
        top_word = stack_q[i];
      end
    end
  end

  assign is_full  = (count_q == CW'(SPSR_DEPTH));
  assign is_empty = (count_q == '0);

  // Restore (and swap) takes priority over wr_en; save and write combine on exception entry.
  always_comb begin
    cpsr_d    = cpsr_q;
    stack_d   = stack_q;
    count_d   = count_q;
    sel_err_d = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    if (restore_en) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        cpsr_d = top_word;
        if (save_en) begin
          for (int i = 0; i < SPSR_DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
              stack_d[i] = cpsr_q;
            end
          end
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    end else begin
      if (wr_en) begin
        if (sel_valid) begin
          cpsr_d = (cpsr_q & ~bit_mask) | (src_word & bit_mask);
        end else begin
          sel_err_d = 1'b1;
        end
      end
      if (save_en) begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < SPSR_DEPTH; i++) begin
            if (count_q == CW'(i)) begin
              stack_d[i] = cpsr_q;
            end
          end
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_q    <= RST_CPSR;
      for (int i = 0; i < SPSR_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      count_q   <= '0;
      sel_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      cpsr_q    <= cpsr_d;
      stack_q   <= stack_d;
      count_q   <= count_d;
      sel_err_q <= sel_err_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign cpsr_out    = cpsr_q;
  assign spsr_top    = top_word;
  assign spsr_count  = count_q;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;
  assign sel_err     = sel_err_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_cpsr_sel_reg.sv
// Directed-vector bench for cpsr_sel_reg with default parameters.
// Expectations for the user-lock case follow CPSR_USER_LOCK_EN when it is defined.
module tb_cpsr_sel_reg;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 5;
  localparam int SEL_W   = 3;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH + 1);

  logic                     clk;
  logic                     rst_n;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]         src_sel;
  logic                     wr_en;
  logic [WIDTH/8-1:0]       field_mask;
  logic                     save_en;
  logic                     restore_en;
  logic [WIDTH-1:0]         cpsr_out;
  logic [WIDTH-1:0]         spsr_top;
  logic [CW-1:0]            spsr_count;
  logic                     stack_full;
  logic                     stack_empty;
  logic                     sel_err;
  logic                     ovf_err;
  logic                     unf_err;

  int checkCount = 0;
  int passCount  = 0;

  cpsr_sel_reg #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
    .SPSR_DEPTH(DEPTH), .RESET_VAL(32'h0000_00D3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_sel(src_sel),
    .wr_en(wr_en), .field_mask(field_mask), .save_en(save_en),
    .restore_en(restore_en), .cpsr_out(cpsr_out), .spsr_top(spsr_top),
    .spsr_count(spsr_count), .stack_full(stack_full), .stack_empty(stack_empty),
    .sel_err(sel_err), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic setSrc(input int k, input logic [31:0] val);
    src_data[k*WIDTH +: WIDTH] = val;
  endtask

  // Drives one request for a single clock and samples 1 time unit after the edge.
  task automatic applyStimulus(input logic wr, input logic [SEL_W-1:0] sel,
                               input logic [3:0] mask, input logic sv, input logic rs);
    wr_en      = wr;
    src_sel    = sel;
    field_mask = mask;
    save_en    = sv;
    restore_en = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    src_data = '0;
    src_sel = '0;
    wr_en = 1'b0;
    field_mask = '0;
    save_en = 1'b0;
    restore_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_cpsr", cpsr_out, 32'h0000_00D3);
    checkOutput("rst_empty", {31'b0, stack_empty}, 32'd1);

    // Masked write of the top byte only
    setSrc(2, 32'hF000_00AA);
    applyStimulus(1'b1, 3'd2, 4'b1000, 1'b0, 1'b0);
    checkOutput("mw_cpsr", cpsr_out, 32'hF000_00D3);
    checkOutput("mw_selerr", {31'b0, sel_err}, 32'd0);

    // Changing sources with wr_en low must not disturb the CPSR
    setSrc(2, 32'h1234_5678);
    applyStimulus(1'b0, 3'd2, 4'b1111, 1'b0, 1'b0);
    checkOutput("hold_cpsr", cpsr_out, 32'hF000_00D3);

    // Invalid select: hold plus a single-cycle sel_err pulse
    applyStimulus(1'b1, 3'd6, 4'b1111, 1'b0, 1'b0);
    checkOutput("bad_sel_cpsr", cpsr_out, 32'hF000_00D3);
    checkOutput("bad_sel_pulse", {31'b0, sel_err}, 32'd1);
    applyStimulus(1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
    checkOutput("bad_sel_clear", {31'b0, sel_err}, 32'd0);

    // Asynchronous reset mid-cycle with a pending write on the inputs
    setSrc(1, 32'hDEAD_BEEF);
    wr_en = 1'b1; src_sel = 3'd1; field_mask = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_cpsr", cpsr_out, 32'h0000_00D3);
    checkOutput("arst_count", {{(32-CW){1'b0}}, spsr_count}, 32'd0);
    checkOutput("arst_top", spsr_top, 32'd0);
    checkOutput("arst_flags", {26'b0, stack_empty, stack_full, sel_err, ovf_err, unf_err, 1'b0}, 32'h20);
    wr_en = 1'b0;
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
    checkOutput("arst_after", cpsr_out, 32'h0000_00D3);

    // Exception entry then return
    setSrc(0, 32'h0000_00D2);
    applyStimulus(1'b1, 3'd0, 4'b0001, 1'b1, 1'b0);
    checkOutput("entry_cpsr", cpsr_out, 32'h0000_00D2);
    checkOutput("entry_top", spsr_top, 32'h0000_00D3);
    checkOutput("entry_count", {{(32-CW){1'b0}}, spsr_count}, 32'd1);
    applyStimulus(1'b0, 3'd0, 4'b0000, 1'b0, 1'b1);
    checkOutput("return_cpsr", cpsr_out, 32'h0000_00D3);
    checkOutput("return_empty", {31'b0, stack_empty}, 32'd1);
    checkOutput("return_top", spsr_top, 32'd0);

    // Five saves into a depth-4 stack, each writing a distinct new CPSR
    for (int i = 1; i <= 5; i++) begin
      setSrc(1, 32'h0000_0100 + i);
      applyStimulus(1'b1, 3'd1, 4'b1111, 1'b1, 1'b0);
    end
    checkOutput("ovf_count", {{(32-CW){1'b0}}, spsr_count}, 32'd4);
    checkOutput("ovf_full", {31'b0, stack_full}, 32'd1);
    checkOutput("ovf_flag", {31'b0, ovf_err}, 32'd1);
    checkOutput("ovf_cpsr", cpsr_out, 32'h0000_0105);
    checkOutput("ovf_top", spsr_top, 32'h0000_0103);

    // Five restores: pops 0x103, 0x102, 0x101, 0xD3, then underflow
    applyStimulus(1'b0, 3'd0, 4'b0000, 1'b0, 1'b1);
    checkOutput("pop1_cpsr", cpsr_out, 32'h0000_0103);
    applyStimulus(1'b0, 3'd0, 4'b0000, 1'b0, 1'b1);
    checkOutput("pop2_cpsr", cpsr_out, 32'h0000_0102);
    applyStimulus(1'b1, 3'd7, 4'b1111, 1'b0, 1'b1);
    checkOutput("pop3_cpsr", cpsr_out, 32'h0000_0101);
    checkOutput("pop3_noselerr", {31'b0, sel_err}, 32'd0);
    applyStimulus(1'b0, 3'd0, 4'b0000, 1'b0, 1'b1);
    checkOutput("pop4_cpsr", cpsr_out, 32'h0000_00D3);
    checkOutput("pop4_unf", {31'b0, unf_err}, 32'd0);
    applyStimulus(1'b1, 3'd1, 4'b1111, 1'b0, 1'b1);
    checkOutput("unf_cpsr", cpsr_out, 32'h0000_00D3);
    checkOutput("unf_count", {{(32-CW){1'b0}}, spsr_count}, 32'd0);
    checkOutput("unf_flag", {31'b0, unf_err}, 32'd1);
    checkOutput("ovf_sticky", {31'b0, ovf_err}, 32'd1);

    // Set up stack top 0x12 and CPSR 0x1F, then swap with wr_en also high
    setSrc(1, 32'h0000_0012);
    applyStimulus(1'b1, 3'd1, 4'b1111, 1'b0, 1'b0);
    setSrc(1, 32'h0000_001F);
    applyStimulus(1'b1, 3'd1, 4'b1111, 1'b1, 1'b0);
    checkOutput("pre_swap_top", spsr_top, 32'h0000_0012);
    setSrc(1, 32'hAAAA_AAAA);
    applyStimulus(1'b1, 3'd1, 4'b1111, 1'b1, 1'b1);
    checkOutput("swap_cpsr", cpsr_out, 32'h0000_0012);
    checkOutput("swap_top", spsr_top, 32'h0000_001F);
    checkOutput("swap_count", {{(32-CW){1'b0}}, spsr_count}, 32'd1);

    // Invalid select combined with save: push still happens
    applyStimulus(1'b1, 3'd5, 4'b1111, 1'b1, 1'b0);
    checkOutput("badsave_cpsr", cpsr_out, 32'h0000_0012);
    checkOutput("badsave_selerr", {31'b0, sel_err}, 32'd1);
    checkOutput("badsave_count", {{(32-CW){1'b0}}, spsr_count}, 32'd2);
    checkOutput("badsave_top", spsr_top, 32'h0000_0012);

    // User-mode write attempt on the control byte
    setSrc(3, 32'h0000_0010);
    applyStimulus(1'b1, 3'd3, 4'b1111, 1'b0, 1'b0);
    checkOutput("user_enter", cpsr_out, 32'h0000_0010);
    setSrc(3, 32'hF000_00D3);
    applyStimulus(1'b1, 3'd3, 4'b1111, 1'b0, 1'b0);
`ifdef CPSR_USER_LOCK_EN
    checkOutput("user_lock", cpsr_out, 32'hF000_0010);
`else
    checkOutput("user_lock", cpsr_out, 32'hF000_00D3);
`endif

    applyStimulus(1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
